// File: rtl/booth_radix4_mult.sv
// booth_radix4_mult: iterative radix-4 Booth multiplier, signed or unsigned per operation.
// Retires two multiplier bits per cycle through a single shared adder/subtractor.
// Ports:
//   clk, clr                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready        operand handshake; in_signed, in_a (multiplicand), in_b (multiplier)
//   out_valid/out_ready      result handshake; product is the full 2*WIDTH-bit result
//   busy                     high while iterating (CALC)
module booth_radix4_mult #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int unsigned N  = WIDTH / 2 + 1;
    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned MW = WIDTH + 2;
    localparam int unsigned AW = WIDTH + 4;
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_n;

    logic [MW-1:0]   m;
    logic [MW-1:0]   q;
    logic [AW-1:0]   a;
    logic            q_m1;
    logic [CW-1:0]   count;

    logic            accept;
    logic            last_iter;
    logic [MW-1:0]   a_ext;
    logic [MW-1:0]   b_ext;
    logic [AW-1:0]   m_sx;
    logic [AW-1:0]   m_x2;
    logic            op_zero;
    logic            op_x2;
    logic            op_neg;
    logic [AW-1:0]   operand;
    logic [AW-1:0]   a_sum;
    logic [AW-1:0]   a_nxt;
    logic [MW-1:0]   q_nxt;
    logic [PW-1:0]   prod_nxt;

    // Handshake decode; a finished result can hand over to new operands in the same cycle.
    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign busy      = (state == CALC);
    assign last_iter = (count == CW'(1));

    // Signedness is captured entirely by the two extension bits of M and Q.
    assign a_ext = in_signed ? {{2{in_a[WIDTH-1]}}, in_a} : {2'b00, in_a};
    assign b_ext = in_signed ? {{2{in_b[WIDTH-1]}}, in_b} : {2'b00, in_b};

    // M and 2M at accumulator width.
    assign m_sx = {{2{m[MW-1]}}, m};
    assign m_x2 = {m[MW-1], m, 1'b0};

    // Booth recoding of {Q[1:0], q_m1}.
    always_comb begin
        op_zero = 1'b1;
        op_x2   = 1'b0;
        op_neg  = 1'b0;
        case ({q[1:0], q_m1})
            3'b001, 3'b010: begin
                op_zero = 1'b0;
            end
            3'b011: begin
                op_zero = 1'b0;
                op_x2   = 1'b1;
            end
            3'b100: begin
                op_zero = 1'b0;
                op_x2   = 1'b1;
                op_neg  = 1'b1;
            end
            3'b101, 3'b110: begin
                op_zero = 1'b0;
                op_neg  = 1'b1;
            end
            default: begin
                op_zero = 1'b1;
            end
        endcase
    end

    // Single adder: subtraction as invert-plus-carry-in.
    assign operand  = op_zero ? '0 : (op_x2 ? m_x2 : m_sx);
    assign a_sum    = a + (operand ^ {AW{op_neg}}) + AW'(op_neg);

    // Arithmetic shift of {A,Q,q_m1} right by two.
    assign a_nxt    = {{2{a_sum[AW-1]}}, a_sum[AW-1:2]};
    assign q_nxt    = {a_sum[1:0], q[MW-1:2]};
    assign prod_nxt = {a_nxt[WIDTH-3:0], q_nxt};

    // FSM state register.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_n = CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = in_valid ? CALC : IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Datapath and result registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            m         <= '0;
            q         <= '0;
            a         <= '0;
            q_m1      <= 1'b0;
            count     <= '0;
            product   <= '0;
            out_valid <= 1'b0;
        end else begin
            if ((state == DONE) && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                m     <= a_ext;
                q     <= b_ext;
                a     <= '0;
                q_m1  <= 1'b0;
                count <= CW'(N);
            end else if (state == CALC) begin
                a     <= a_nxt;
                q     <= q_nxt;
                q_m1  <= q[1];
                count <= count - CW'(1);
                if (last_iter) begin
                    product   <= prod_nxt;
                    out_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_booth_radix4_mult.sv
// tb_booth_radix4_mult: directed checks of booth_radix4_mult at WIDTH=16 and WIDTH=8.
module tb_booth_radix4_mult;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=16 instance
    logic        clr_16;
    logic        in_valid_16;
    logic        in_ready_16;
    logic        in_signed_16;
    logic [15:0] in_a_16;
    logic [15:0] in_b_16;
    logic        out_valid_16;
    logic        out_ready_16;
    logic [31:0] product_16;
    logic        busy_16;

    // WIDTH=8 instance
    logic        clr_8;
    logic        in_valid_8;
    logic        in_ready_8;
    logic        in_signed_8;
    logic [7:0]  in_a_8;
    logic [7:0]  in_b_8;
    logic        out_valid_8;
    logic        out_ready_8;
    logic [15:0] product_8;
    logic        busy_8;

    int ncmp  = 0;
    int nfail = 0;

    booth_radix4_mult #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .clr       (clr_16),
        .in_valid  (in_valid_16),
        .in_ready  (in_ready_16),
        .in_signed (in_signed_16),
        .in_a      (in_a_16),
        .in_b      (in_b_16),
        .out_valid (out_valid_16),
        .out_ready (out_ready_16),
        .product   (product_16),
        .busy      (busy_16)
    );

    booth_radix4_mult #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .clr       (clr_8),
        .in_valid  (in_valid_8),
        .in_ready  (in_ready_8),
        .in_signed (in_signed_8),
        .in_a      (in_a_8),
        .in_b      (in_b_8),
        .out_valid (out_valid_8),
        .out_ready (out_ready_8),
        .product   (product_8),
        .busy      (busy_8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One 16-bit operation with out_ready held high; latency counts the accept cycle as 0.
    task automatic run16(input logic s, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp, input string tag);
        int cyc;
        in_signed_16 = s;
        in_a_16      = a;
        in_b_16      = b;
        in_valid_16  = 1'b1;
        out_ready_16 = 1'b1;
        check({tag, "_in_ready"}, 32'(in_ready_16), 32'd1);
        tick();
        in_valid_16 = 1'b0;
        check({tag, "_busy"}, 32'(busy_16), 32'd1);
        cyc = 1;
        while (!out_valid_16 && cyc < 40) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'd10);
        check({tag, "_product"}, product_16, exp);
        tick();
        check({tag, "_retired"}, 32'(out_valid_16), 32'd0);
    endtask

    // One 8-bit operation with a random consumer stall before retiring.
    task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b);
        int cyc;
        logic [15:0] ax;
        logic [15:0] bx;
        logic [15:0] exp;
        ax  = s ? {{8{a[7]}}, a} : {8'h00, a};
        bx  = s ? {{8{b[7]}}, b} : {8'h00, b};
        exp = ax * bx;
        in_signed_8 = s;
        in_a_8      = a;
        in_b_8      = b;
        in_valid_8  = 1'b1;
        out_ready_8 = 1'b0;
        tick();
        in_valid_8 = 1'b0;
        cyc = 0;
        while (!out_valid_8 && cyc < 40) begin
            tick();
            cyc++;
        end
        repeat ($urandom_range(0, 3)) tick();
        check($sformatf("w8_%0d_%02h_%02h", s, a, b), {16'h0, product_8}, {16'h0, exp});
        out_ready_8 = 1'b1;
        tick();
        out_ready_8 = 1'b0;
    endtask

    logic [7:0] vals [8] = '{8'h00, 8'h01, 8'h02, 8'h55, 8'h7F, 8'h80, 8'hAA, 8'hFF};

    initial begin
        int cyc;
        clr_16 = 1'b1; in_valid_16 = 1'b0; in_signed_16 = 1'b0;
        in_a_16 = '0; in_b_16 = '0; out_ready_16 = 1'b0;
        clr_8 = 1'b1; in_valid_8 = 1'b0; in_signed_8 = 1'b0;
        in_a_8 = '0; in_b_8 = '0; out_ready_8 = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_in_ready",  32'(in_ready_16),  32'd1);
        check("rst_out_valid", 32'(out_valid_16), 32'd0);
        check("rst_busy",      32'(busy_16),      32'd0);
        check("rst_product",   product_16,        32'd0);
        clr_16 = 1'b0;
        clr_8  = 1'b0;
        tick();

        // Directed 16-bit products
        run16(1'b1, 16'h8000, 16'h8000, 32'h40000000, "smin_smin");
        run16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "umax_umax");
        run16(1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001, "sm1_sm1");
        run16(1'b1, 16'hFFFF, 16'h0001, 32'hFFFFFFFF, "sm1_p1");
        run16(1'b1, 16'h0000, 16'h1234, 32'h00000000, "zero");
        run16(1'b0, 16'h1234, 16'h5678, 32'h06260060, "u_1234_5678");
        run16(1'b1, 16'hFFFE, 16'h0003, 32'hFFFFFFFA, "s_m2_3");
        run16(1'b0, 16'hFFFE, 16'h0003, 32'h0002FFFA, "u_fffe_3");

        // Consumer stall with new operands waiting
        in_signed_16 = 1'b1; in_a_16 = 16'd3; in_b_16 = 16'd5;
        in_valid_16 = 1'b1; out_ready_16 = 1'b0;
        tick();
        in_valid_16 = 1'b0;
        cyc = 0;
        while (!out_valid_16 && cyc < 40) begin
            tick();
            cyc++;
        end
        check("stall_first_valid", 32'(out_valid_16), 32'd1);
        in_signed_16 = 1'b0; in_a_16 = 16'd7; in_b_16 = 16'd9; in_valid_16 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall_product_%0d", k), product_16, 32'h0000000F);
            check($sformatf("stall_valid_%0d", k), 32'(out_valid_16), 32'd1);
            check($sformatf("stall_in_ready_%0d", k), 32'(in_ready_16), 32'd0);
            tick();
        end
        check("stall_busy_held", 32'(busy_16), 32'd0);
        out_ready_16 = 1'b1;
        #1;
        check("handover_in_ready", 32'(in_ready_16), 32'd1);
        tick();
        in_valid_16 = 1'b0;
        check("handover_valid_drop", 32'(out_valid_16), 32'd0);
        check("handover_busy", 32'(busy_16), 32'd1);
        cyc = 1;
        while (!out_valid_16 && cyc < 40) begin
            tick();
            cyc++;
        end
        check("handover_latency", 32'(cyc), 32'd10);
        check("handover_product", product_16, 32'h0000003F);
        tick();

        // Reset during iteration 4
        in_signed_16 = 1'b0; in_a_16 = 16'h1234; in_b_16 = 16'h5678;
        in_valid_16 = 1'b1; out_ready_16 = 1'b1;
        tick();
        in_valid_16 = 1'b0;
        repeat (3) tick();
        check("clr_pre_busy", 32'(busy_16), 32'd1);
        clr_16 = 1'b1;
        tick();
        clr_16 = 1'b0;
        check("clr_in_ready",  32'(in_ready_16),  32'd1);
        check("clr_out_valid", 32'(out_valid_16), 32'd0);
        check("clr_product",   product_16,        32'd0);
        check("clr_busy",      32'(busy_16),      32'd0);
        repeat (12) tick();
        check("clr_no_late_valid", 32'(out_valid_16), 32'd0);
        check("clr_product_late",  product_16,        32'd0);

        // 8-bit corner sweep in both modes, then random operands
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 8; i++) begin
                for (int j = 0; j < 8; j++) begin
                    run8(1'(s), vals[i], vals[j]);
                end
            end
        end
        for (int r = 0; r < 100; r++) begin
            run8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
